// File: rtl/updown_counter_reg_pkg.sv
// Shared types for the multi-byte up/down counter register.
// The edge operation is a strict priority pick: clear, then commit, then count.
package updown_counter_reg_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_CLEAR  = 2'd1,
    OP_COMMIT = 2'd2,
    OP_COUNT  = 2'd3
  } op_e;

  function automatic op_e pick_op(input logic clr, input logic commit, input logic count);
    if (clr) begin
      return OP_CLEAR;
    end else if (commit) begin
      return OP_COMMIT;
    end else if (count) begin
      return OP_COUNT;
    end
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/tri_state_buffer.sv
// Generic tri-state buffer: drives data_o with data_i when en_i is high, high-Z otherwise.
module tri_state_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  en_i,
  output wire  [DATA_WIDTH-1:0] data_o
);

  assign data_o = en_i ? data_i : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/updown_counter_reg.sv
// Multi-byte up/down counter register with staged atomic writes, snapshot reads,
// wrap or saturate on terminal count, and a sticky overflow flag.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module updown_counter_reg
  import updown_counter_reg_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NBYTES     = 2,
  parameter int SATURATE   = 0,
  parameter int SELW       = $clog2(NBYTES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           CS,
  input  logic                           WE,
  input  logic                           OE,
  input  logic [SELW-1:0]                SEL,
  input  logic                           CNT_EN,
  input  logic                           DIR,
  input  logic                           SYNC_CLR,
  input  logic                           CLR_OVF,
  input  logic                           OE_A,
  inout  wire  [DATA_WIDTH-1:0]          data,
  output wire  [NBYTES*DATA_WIDTH-1:0]   address,
  output logic [NBYTES*DATA_WIDTH-1:0]   value,
  output logic                           carry,
  output logic                           ovf
);

  localparam int W  = NBYTES * DATA_WIDTH;
  localparam int HW = W - DATA_WIDTH;

  logic [W-1:0]          value_q, value_d, step_val;
  logic [HW-1:0]         stage_q, stage_d, snap_q, snap_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_en, rd_en, cnt_en, sel_zero, at_term, ovf_set;
  logic [DATA_WIDTH-1:0] rd_dat;
  op_e                   op;

  assign wr_en    = CS & WE;
  assign rd_en    = CS & OE & ~WE;
  assign cnt_en   = CS & CNT_EN;
  assign sel_zero = (SEL == '0);

  assign at_term  = DIR ? (&value_q) : ~(|value_q);
  assign carry    = cnt_en & at_term;
  assign step_val = DIR ? (value_q + W'(1)) : (value_q - W'(1));

  assign op       = pick_op(SYNC_CLR, wr_en & sel_zero, cnt_en);
  // Overflow only counts when the step was actually taken, not pre-empted.
  assign ovf_set  = (op == OP_COUNT) & at_term;

  always_comb begin
    value_d = value_q;
    stage_d = stage_q;
    case (op)
      OP_CLEAR: begin
        value_d = '0;
        stage_d = '0;
      end
      OP_COMMIT: value_d = {stage_q, data};
      OP_COUNT: begin
        if (!(at_term && (SATURATE != 0))) begin
          value_d = step_val;
        end
      end
      default: ;
    endcase
    if ((op != OP_CLEAR) && wr_en) begin
      for (int k = 1; k < NBYTES; k++) begin
        if (int'(SEL) == k) begin
          stage_d[(k-1)*DATA_WIDTH +: DATA_WIDTH] = data;
        end
      end
    end
  end

  assign ovf_d  = ovf_set ? 1'b1 : (CLR_OVF ? 1'b0 : ovf_q);
  // Reading lane 0 freezes the upper lanes so later lane reads are coherent.
  assign snap_d = (rd_en & sel_zero) ? value_q[W-1:DATA_WIDTH] : snap_q;

  always_comb begin
    rd_dat = '0;
    if (sel_zero) begin
      rd_dat = value_q[DATA_WIDTH-1:0];
    end else begin
      for (int k = 1; k < NBYTES; k++) begin
        if (int'(SEL) == k) begin
          rd_dat = snap_q[(k-1)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      stage_q <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      stage_q <= stage_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data  = rd_en ? rd_dat : {DATA_WIDTH{1'bz}};
  assign value = value_q;
  assign ovf   = ovf_q;

  tri_state_buffer #(
    .DATA_WIDTH(W)
  ) u_addr_buf (
    .data_i(value_q),
    .en_i  (OE_A),
    .data_o(address)
  );

endmodule

// File: tb/tb_updown_counter_reg.sv
// Directed bench: a wrapping and a saturating instance share all control inputs;
// undriven buses are pulled up so high-Z reads back as all-ones.
module tb_updown_counter_reg;

  logic        clk;
  logic        reset;
  logic        CS, WE, OE, CNT_EN, DIR, SYNC_CLR, CLR_OVF, OE_A;
  logic [0:0]  SEL;
  logic [7:0]  tb_dat;
  logic        tb_den;

  wire  [7:0]  data_a, data_b;
  wire  [15:0] address_a, address_b;
  logic [15:0] value_a, value_b;
  logic        carry_a, carry_b, ovf_a, ovf_b;

  int total = 0;
  int bad   = 0;

  assign data_a = tb_den ? tb_dat : 8'bz;
  assign data_b = tb_den ? tb_dat : 8'bz;
  pullup (data_a);
  pullup (data_b);
  pullup (address_a);
  pullup (address_b);

  updown_counter_reg #(.DATA_WIDTH(8), .NBYTES(2), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .CS(CS), .WE(WE), .OE(OE), .SEL(SEL),
    .CNT_EN(CNT_EN), .DIR(DIR), .SYNC_CLR(SYNC_CLR), .CLR_OVF(CLR_OVF), .OE_A(OE_A),
    .data(data_a), .address(address_a), .value(value_a), .carry(carry_a), .ovf(ovf_a)
  );

  updown_counter_reg #(.DATA_WIDTH(8), .NBYTES(2), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .CS(CS), .WE(WE), .OE(OE), .SEL(SEL),
    .CNT_EN(CNT_EN), .DIR(DIR), .SYNC_CLR(SYNC_CLR), .CLR_OVF(CLR_OVF), .OE_A(OE_A),
    .data(data_b), .address(address_b), .value(value_b), .carry(carry_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; CS = 1'b0; WE = 1'b0; OE = 1'b0; SEL = 1'b0; CNT_EN = 1'b0;
    DIR = 1'b1; SYNC_CLR = 1'b0; CLR_OVF = 1'b0; OE_A = 1'b0; tb_dat = 8'h00; tb_den = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_value", value_a, 32'h0000);
    chk("rst_ovf", ovf_a, 32'h0);
    chk("rst_carry", carry_a, 32'h0);
    chk("rst_data_z", data_a, 32'hFF);
    chk("rst_addr_z", address_a, 32'hFFFF);
    reset = 1'b1;
    tick();

    // Load 0x00A5, count once, then reset between edges
    CS = 1'b1; WE = 1'b1; SEL = 1'b0; tb_den = 1'b1; tb_dat = 8'hA5;
    tick();
    chk("load_a5", value_a, 32'h00A5);
    WE = 1'b0; tb_den = 1'b0; CNT_EN = 1'b1; DIR = 1'b1;
    tick();
    chk("count_a6", value_a, 32'h00A6);
    #2 reset = 1'b0;
    #1;
    chk("midrst_value_a", value_a, 32'h0000);
    chk("midrst_value_b", value_b, 32'h0000);
    chk("midrst_ovf", ovf_a, 32'h0);
    chk("midrst_data_z", data_a, 32'hFF);
    chk("midrst_addr_z", address_a, 32'hFFFF);
    CNT_EN = 1'b0;
    reset = 1'b1;
    tick();

    // Staged high byte, count meanwhile, then atomic commit beats count
    WE = 1'b1; SEL = 1'b1; tb_den = 1'b1; tb_dat = 8'h12;
    tick();
    chk("stage_no_effect", value_a, 32'h0000);
    WE = 1'b0; tb_den = 1'b0; CNT_EN = 1'b1;
    tick(); tick(); tick();
    chk("count3", value_a, 32'h0003);
    WE = 1'b1; SEL = 1'b0; tb_den = 1'b1; tb_dat = 8'h34;
    tick();
    chk("commit_1234_a", value_a, 32'h1234);
    chk("commit_1234_b", value_b, 32'h1234);

    // Up-count overflow: wrap vs saturate
    CNT_EN = 1'b0; SEL = 1'b1; tb_dat = 8'hFF;
    tick();
    SEL = 1'b0;
    tick();
    chk("load_ffff", value_a, 32'hFFFF);
    WE = 1'b0; tb_den = 1'b0; CNT_EN = 1'b1; DIR = 1'b1;
    #1;
    chk("carry_pre_a", carry_a, 32'h1);
    chk("carry_pre_b", carry_b, 32'h1);
    tick();
    chk("wrap_value", value_a, 32'h0000);
    chk("wrap_ovf", ovf_a, 32'h1);
    chk("sat_value", value_b, 32'hFFFF);
    chk("sat_ovf", ovf_b, 32'h1);
    chk("sat_carry_held", carry_b, 32'h1);
    chk("wrap_carry_after", carry_a, 32'h0);

    // CLR_OVF alone, then overflow and CLR_OVF on the same edge
    CNT_EN = 1'b0; CLR_OVF = 1'b1;
    tick();
    chk("clr_ovf_a", ovf_a, 32'h0);
    CNT_EN = 1'b1; DIR = 1'b0;
    #1;
    chk("carry_down_a", carry_a, 32'h1);
    tick();
    chk("down_wrap_value", value_a, 32'hFFFF);
    chk("set_beats_clr", ovf_a, 32'h1);
    chk("down_b_value", value_b, 32'hFFFE);
    chk("down_b_ovf", ovf_b, 32'h0);
    CNT_EN = 1'b0;
    tick();
    chk("clr_ovf_next", ovf_a, 32'h0);
    CLR_OVF = 1'b0;

    // Down count across the byte boundary
    WE = 1'b1; tb_den = 1'b1; SEL = 1'b1; tb_dat = 8'h01;
    tick();
    SEL = 1'b0; tb_dat = 8'h00;
    tick();
    WE = 1'b0; tb_den = 1'b0; DIR = 1'b0; CNT_EN = 1'b1;
    tick();
    chk("down_boundary", value_a, 32'h00FF);
    chk("down_boundary_carry", carry_a, 32'h0);

    // Coherent read across the 0x00FF -> 0x0100 roll
    DIR = 1'b1; OE = 1'b1; SEL = 1'b0;
    #1;
    chk("read_lo", data_a, 32'hFF);
    tick();
    SEL = 1'b1;
    #1;
    chk("read_snapshot_hi", data_a, 32'h00);
    chk("live_value", value_a, 32'h0100);
    CNT_EN = 1'b0; OE_A = 1'b1;
    #1;
    chk("addr_drive", address_a, 32'h0100);
    WE = 1'b1;
    #1;
    chk("we_over_oe", data_a, 32'hFF);
    WE = 1'b0; OE = 1'b0; OE_A = 1'b0;
    tick();

    // SYNC_CLR beats commit and count; staging is cleared too
    SYNC_CLR = 1'b1; WE = 1'b1; SEL = 1'b0; tb_den = 1'b1; tb_dat = 8'h55; CNT_EN = 1'b1; DIR = 1'b1;
    tick();
    chk("clr_prio_a", value_a, 32'h0000);
    chk("clr_prio_b", value_b, 32'h0000);
    SYNC_CLR = 1'b0; CNT_EN = 1'b0; tb_dat = 8'h77;
    tick();
    chk("stage_cleared", value_a, 32'h0077);

    // Saturating down count holds at zero
    WE = 1'b0; tb_den = 1'b0; SYNC_CLR = 1'b1;
    tick();
    SYNC_CLR = 1'b0; DIR = 1'b0; CNT_EN = 1'b1;
    tick();
    chk("down_wrap_a", value_a, 32'hFFFF);
    chk("down_sat_b", value_b, 32'h0000);
    chk("down_sat_ovf_b", ovf_b, 32'h1);
    CNT_EN = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/updown_counter_reg.md
# updown_counter_reg

Parametrised multi-byte up/down counter register, the successor to the 8-bit counter and the 16-bit PC register. It has NBYTES byte lanes behind one DATA_WIDTH data bus and a selectable count direction. Overflow can either wrap or saturate, and a sticky overflow flag records it. Multi-byte writes commit atomically and multi-byte reads are coherent snapshots. It is the building block for the stack pointer and the loop/index registers, and can also replace the PC register.

## Interface
- DATA_WIDTH, default `DATA_WIDTH (8): width of one byte lane and of the data bus.
- NBYTES, default 2: number of byte lanes, must be at least 2; the full value width is W = NBYTES*DATA_WIDTH.
- SATURATE, default 0: 0 means the count wraps, 1 means it holds at the terminal value.
- SELW, default $clog2(NBYTES), derived: width of SEL.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- CS  in  1  chip select; qualifies WE, OE and CNT_EN.
- WE  in  1  write strobe for the byte lane chosen by SEL.
- OE  in  1  read strobe; drives data with the byte lane chosen by SEL.
- SEL  in  SELW  byte-lane select; 0 is the least significant lane.
- CNT_EN  in  1  count enable.
- DIR  in  1  count direction; 1 counts up, 0 counts down.
- SYNC_CLR  in  1  synchronous clear.
- CLR_OVF  in  1  synchronous clear of the overflow flag.
- OE_A  in  1  address output enable.
- data  inout  DATA_WIDTH  shared data bus.
- address  out  W  value onto the address bus; high-Z when OE_A=0.
- value  out  W  live counter value, always driven.
- carry  out  1  combinational terminal-count flag.
- ovf  out  1  sticky overflow flag.

## Operation
- State:
  - value register (W bits)
  - staging register (bytes 1..NBYTES-1)
  - snapshot register (bytes 1..NBYTES-1)
  - ovf
- Reset (reset=0): value, staging, snapshot and ovf all go to 0 immediately, independent of clk; this also applies mid-operation.
- Per-edge priority for the value register:
  1. SYNC_CLR: value becomes 0 and staging becomes 0; ovf is unchanged.
  2. Commit: when CS&WE and SEL=0, value becomes {staging, data}. Any count in the same cycle is discarded.
  3. Count: when CS&CNT_EN, value becomes value+1 (DIR=1) or value-1 (DIR=0), modulo 2^W.
  4. Otherwise value holds.
- Staged write: when CS&WE and SEL=k with k>0, staging byte k takes data. value is untouched, and counting continues meanwhile.
- If SEL is at or beyond NBYTES, writes are ignored and reads return 0.
- Terminal count: the terminal value is all-ones when DIR=1 and all-zeros when DIR=0. carry = CS&CNT_EN&(value at the terminal value).
- Overflow: a count step taken while carry=1 wraps when SATURATE=0 and holds when SATURATE=1. In both cases ovf is set on that edge.
- CLR_OVF clears ovf, but a set on the same edge wins.
- Reads: when CS&OE&~WE, data carries value byte 0 if SEL=0, else snapshot byte SEL. Otherwise data is high-Z; WE overrides OE.
- Snapshot: on every edge where CS&OE&~WE and SEL=0, snapshot takes value bytes 1..NBYTES-1. Reading byte 0 first and then the higher bytes therefore gives a coherent value.

## Timing
- Writes and commits: data is sampled on the rising edge, and the new value is visible on value/address after that edge (1-cycle latency).
- Count: 1 step per enabled edge; there is no multi-cycle ripple, and carry is combinational from value, CNT_EN, CS and DIR.
- The data and address tri-states follow OE/CS/WE/SEL and OE_A combinationally.
- Reset values: value=0, address=Z (OE_A-dependent), carry=0, ovf=0, data=Z.

## Structure
- DATA_WIDTH comes from the shared `DATA_WIDTH define in the common defines header.
- No new shared constants are needed; SELW is local.
- The address output reuses the existing tri_state_buffer with DATA_WIDTH=W. No other sub-module is needed: the value register is behavioural, with no jk_ff/latch chain.
- A PC-compatible wrapper can drive CNT_EN with DIR tied to 1 and SATURATE=0.

## Test plan
All scenarios use DATA_WIDTH=8, NBYTES=2.
- **Reset:** counting up from 0x00A5, pull reset low between edges → value=0x0000, ovf=0 immediately, and data/address are Z.
- **Atomic write:** SEL=1 write 0x12, then 3 count-up edges from 0 → value=0x0003. Then SEL=0 write 0x34 while CNT_EN=1 → value=0x1234 after the edge, with no increment.
- **Wrap/saturate:** with 0xFFFF loaded and DIR=1, carry=1 before the edge. After it, value=0x0000 and ovf=1 (SATURATE=0), or value=0xFFFF and ovf=1 (SATURATE=1). With 0x0000 loaded and DIR=0 → value=0xFFFF.
- **Down count across the byte boundary:** 0x0100 with DIR=0 → 0x00FF and carry=0.
- **Coherent read:** value=0x00FF counting up; SEL=0 read returns 0xFF. Next cycle value=0x0100, and a SEL=1 read returns 0x00 (the snapshot), not 0x01.
- **Priority:**
  - SYNC_CLR+commit+CNT_EN on one edge → value=0x0000.
  - Overflow plus CLR_OVF on one edge → ovf=1; CLR_OVF alone on the next edge → ovf=0.
